multdiv_unit: RTL and testbench

Iterative 32-bit signed multiply/divide unit used by the execute stage of the 5-stage pipelined processor for `mul` and `div`. Execute pulses a start strobe with both operands, then holds PC, the F/D latch and a NOP in D/X while `busy` is high. The unit returns the result and an exception flag on a one-cycle ready pulse. The processor then writes the result to `$rd`, or writes the rstatus code to `$r30` if the exception flag is set.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_counter.sv | 27 ++
 rtl/multdiv_unit.sv | 131 +++++++++++++
 tb/tb_multdiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants for the iterative multiply/divide unit
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Written to $r30 by writeback when data_exception is set
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - iteration counter with clear, enable and terminal count
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter logic [CNT_W-1:0] LAST = CNT_W'(MD_WIDTH - 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CNT_W'(1);
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply (radix-2 Booth) / divide (non-restoring)
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [2*WIDTH:0]   prodReg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH+1:0]   remReg;
    logic               negQ;
    logic               divZero;
    logic               divOvf;
    logic               lastStep;
    logic               startOk;

    assign startOk = (state == S_IDLE || state == S_DONE) && (ctrl_MULT || ctrl_DIV);

    multdiv_counter #(.LAST(CNT_W'(WIDTH - 1))) iterCounter (
        .clock    (clock),
        .reset    (reset),
        .clear    (startOk),
        .enable   (state == S_MUL || state == S_DIV),
        .terminal (lastStep)
    );

    // Booth step: the sum is kept one bit wider so subtracting the most negative multiplicand cannot wrap
    logic [WIDTH:0]   boothSum;
    logic [2*WIDTH:0] prodNext;
    logic             mulOvf;

    always_comb begin
        boothSum = {prodReg[2*WIDTH], prodReg[2*WIDTH:WIDTH+1]};
        case (prodReg[1:0])
            2'b01:   boothSum = boothSum + {mcand[WIDTH-1], mcand};
            2'b10:   boothSum = boothSum - {mcand[WIDTH-1], mcand};
            default: boothSum = boothSum;
        endcase
        prodNext = {boothSum, prodReg[WIDTH:1]};
        mulOvf   = !((&prodNext[2*WIDTH:WIDTH]) || !(|prodNext[2*WIDTH:WIDTH]));
    end

    // Non-restoring step on magnitudes; the quotient needs no final correction
    logic [WIDTH+1:0] remShift;
    logic [WIDTH+1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] divQuot;

    always_comb begin
        remShift = {remReg[WIDTH:0], quoReg[WIDTH-1]};
        remNext  = remReg[WIDTH+1] ? remShift + {2'b00, divisor} : remShift - {2'b00, divisor};
        quoNext  = {quoReg[WIDTH-2:0], ~remNext[WIDTH+1]};
        divQuot  = negQ ? -quoNext : quoNext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            prodReg        <= '0;
            mcand          <= '0;
            divisor        <= '0;
            quoReg         <= '0;
            remReg         <= '0;
            negQ           <= 1'b0;
            divZero        <= 1'b0;
            divOvf         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (startOk) begin
                state          <= ctrl_MULT ? S_MUL : S_DIV;
                mcand          <= data_operandA;
                prodReg        <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                quoReg         <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
                divisor        <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
                remReg         <= '0;
                negQ           <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                divZero        <= (data_operandB == '0);
                divOvf         <= (data_operandA == MIN_VAL) && (&data_operandB);
                data_exception <= 1'b0;
                busy           <= 1'b1;
            end else begin
                case (state)
                    S_MUL: begin
                        prodReg <= prodNext;
                        if (lastStep) begin
                            state          <= S_DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= prodNext[WIDTH:1];
                            data_exception <= mulOvf;
                        end
                    end
                    S_DIV: begin
                        remReg <= remNext;
                        quoReg <= quoNext;
                        if (lastStep) begin
                            state          <= S_DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= divZero ? '0 : divQuot;
                            data_exception <= divZero | divOvf;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit against an arithmetic reference
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] result;
        logic        exc;
        int          startCycle;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int busyCount = 0;
    logic prevRdy = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic, division truncating toward zero
    task automatic model(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        logic signed [63:0] p;
        int q;
        if (isMul) begin
            p = 64'($signed(a)) * 64'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        expect_t e;
        if (reset) begin
            busyCount = 0;
            prevRdy = 1'b0;
        end else begin
            if (busy) busyCount++;
            if (data_resultRDY) begin
                check("rdy_single_cycle", 32'(prevRdy), 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got result 0x%08h with no operation outstanding", data_result);
                end else begin
                    e = expQ.pop_front();
                    check("result", data_result, e.result);
                    check("exception", 32'(data_exception), 32'(e.exc));
                    check("latency", 32'(cycleCnt - e.startCycle), 32'd32);
                    check("busy_cycles", 32'(busyCount), 32'd32);
                    check("busy_low_at_rdy", 32'(busy), 32'd0);
                end
                busyCount = 0;
            end
            prevRdy = data_resultRDY;
        end
    end

    // Drives a start for the next rising edge, then records the expectation against that edge
    task automatic issue(input bit mulBit, input bit divBit, input logic [31:0] a, input logic [31:0] b);
        expect_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mulBit;
        ctrl_DIV = divBit;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        model(mulBit, a, b, e.result, e.exc);
        e.startCycle = cycleCnt;
        expQ.push_back(e);
    endtask

    task automatic waitRdy();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (data_resultRDY) return;
        end
        checks++;
        errors++;
        $display("FAIL rdy_timeout: got no RDY within 50 cycles, expected one at cycle 32");
    endtask

    // Optionally throws a stray start strobe mid-operation at cycle junkAt
    task automatic runOp(input bit isMul, input logic [31:0] a, input logic [31:0] b, input int junkAt);
        issue(isMul, !isMul, a, b);
        if (junkAt > 0) begin
            repeat (junkAt - 1) @(negedge clock);
            ctrl_MULT = $urandom_range(0, 1);
            ctrl_DIV = 1'b1;
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV = 1'b0;
        end
        waitRdy();
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] edgeVals[6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        case ($urandom_range(0, 3))
            0: return edgeVals[$urandom_range(0, 5)];
            1: return 32'($signed(16'($urandom)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", 32'(data_exception), 32'd0);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        #2 reset = 1'b0;
        @(negedge clock);

        runOp(1'b1, 32'd7, 32'hFFFF_FFFD, 0);
        runOp(1'b1, 32'h0001_0000, 32'h0001_0000, 0);
        runOp(1'b1, 32'h7FFF_FFFF, 32'd1, 0);
        runOp(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        runOp(1'b0, 32'd100, 32'hFFFF_FFF6, 0);
        runOp(1'b0, 32'd5, 32'd0, 0);
        check("hold_result_after_done", data_result, 32'd0);
        @(negedge clock);
        check("hold_exception_in_idle", 32'(data_exception), 32'd1);
        runOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        runOp(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        @(negedge clock);

        // Stray DIV mid-multiply, then back-to-back start in the DONE cycle
        runOp(1'b1, 32'd6, 32'd4, 5);
        runOp(1'b0, 32'd1000, 32'd7, 0);
        @(negedge clock);

        for (int n = 0; n < 24; n++) begin
            runOp($urandom_range(0, 1), pickOperand(), pickOperand(),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        @(negedge clock);

        // Asynchronous reset in the middle of a divide
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdy", 32'(data_resultRDY), 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_exception", 32'(data_exception), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (40) @(negedge clock);
        issue(1'b1, 1'b1, 32'd6, 32'd4);
        waitRdy();

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
